// File: rtl/data_mem_stage.sv
// MEM-stage data memory with a fixed multi-cycle array latency and upstream stall.
// Optional misaligned-access check enabled by defining DMEM_MISALIGN_CHK_EN.
module data_mem_stage #(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 3
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        MemRead_i,
  input  logic        MemWrite_i,
  input  logic [31:0] Addr_i,
  input  logic [31:0] WriteData_i,
  output logic        stall_o,
  output logic        mem_done_o,
  output logic [31:0] ReadData_o,
  output logic        misalign_o
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [31:0]     wdata_q, wdata_d;
  logic            store_q, store_d;
  logic            mis_q, mis_d;
  logic [31:0]     rdata_q, rdata_d;
  logic            done_q, done_d;
  logic            misalign_q, misalign_d;
  logic            req_s;
  logic            mis_s;
  logic            stall_s;
  logic            mem_we_s;
  logic            unused_addr_s;

  logic [31:0]     mem_q [DEPTH_WORDS];

  assign req_s         = MemRead_i | MemWrite_i;
  // Upper address bits wrap; low bits only matter when the misalign check is built in.
  assign unused_addr_s = ^{Addr_i[31:AW+2], Addr_i[1:0]};

`ifdef DMEM_MISALIGN_CHK_EN
  assign mis_s = (Addr_i[1:0] != 2'b00);
`else
  assign mis_s = 1'b0;
`endif

  // Next-state, capture and access decode for the IDLE/BUSY/DONE sequencer.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    store_d    = store_q;
    mis_d      = mis_q;
    rdata_d    = rdata_q;
    done_d     = 1'b0;
    misalign_d = 1'b0;
    stall_s    = 1'b0;
    mem_we_s   = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_s) begin
          stall_s = 1'b1;
          addr_d  = Addr_i[AW+1:2];
          wdata_d = WriteData_i;
          store_d = MemWrite_i;
          mis_d   = mis_s;
          cnt_d   = CNT_INIT;
          state_d = BUSY;
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        stall_s = 1'b1;
        if (cnt_q != {CW{1'b0}}) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          // A misaligned request keeps the timing but touches nothing.
          if (mis_q) begin
            mem_we_s = 1'b0;
          end else if (store_q) begin
            mem_we_s = 1'b1;
          end else begin
            rdata_d = mem_q[addr_q];
          end
          done_d     = 1'b1;
          misalign_d = mis_q;
          state_d    = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Sequencer and output registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      cnt_q      <= {CW{1'b0}};
      addr_q     <= {AW{1'b0}};
      wdata_q    <= 32'h0000_0000;
      store_q    <= 1'b0;
      mis_q      <= 1'b0;
      rdata_q    <= 32'h0000_0000;
      done_q     <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      store_q    <= store_d;
      mis_q      <= mis_d;
      rdata_q    <= rdata_d;
      done_q     <= done_d;
      misalign_q <= misalign_d;
    end
  end

  // Array write port; reset in the commit cycle aborts the store.
  always_ff @(posedge clk_i) begin
    if (mem_we_s && !rst_i) begin
      mem_q[addr_q] <= wdata_q;
    end
  end

  assign stall_o    = stall_s;
  assign mem_done_o = done_q;
  assign ReadData_o = rdata_q;
  assign misalign_o = misalign_q;

endmodule

// File: tb/tb_data_mem_stage.sv
// Directed, table-driven bench for data_mem_stage (LATENCY=3, DEPTH_WORDS=256).
module tb_data_mem_stage;

  localparam int LATENCY = 3;
`ifdef DMEM_MISALIGN_CHK_EN
  localparam bit MIS_EN = 1'b1;
`else
  localparam bit MIS_EN = 1'b0;
`endif

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        MemRead_i;
  logic        MemWrite_i;
  logic [31:0] Addr_i;
  logic [31:0] WriteData_i;
  logic        stall_o;
  logic        mem_done_o;
  logic [31:0] ReadData_o;
  logic        misalign_o;

  int pass_cnt  = 0;
  int total_cnt = 0;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic        exp_mis;
  } vec_t;

  vec_t        tbl [13];
  logic [31:0] last_r;

  data_mem_stage #(.DEPTH_WORDS(256), .LATENCY(LATENCY)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .MemRead_i   (MemRead_i),
    .MemWrite_i  (MemWrite_i),
    .Addr_i      (Addr_i),
    .WriteData_i (WriteData_i),
    .stall_o     (stall_o),
    .mem_done_o  (mem_done_o),
    .ReadData_o  (ReadData_o),
    .misalign_o  (misalign_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // One complete access: stall length, done pulse, data and misalign flag.
  task automatic access(input vec_t v, input int idx);
    int n;
    n = 0;
    MemRead_i   = v.rd;
    MemWrite_i  = v.wr;
    Addr_i      = v.addr;
    WriteData_i = v.wdata;
    #1;
    while (stall_o === 1'b1 && n < 20) begin
      n++;
      tick();
      if (n == 1) begin
        Addr_i      = ~v.addr;
        WriteData_i = ~v.wdata;
      end
      #1;
    end
    chk($sformatf("v%0d_stall_cycles", idx), 32'(n), 32'(LATENCY + 1));
    chk($sformatf("v%0d_done", idx), 32'(mem_done_o), 32'd1);
    chk($sformatf("v%0d_rdata", idx), ReadData_o, v.exp_rd);
    chk($sformatf("v%0d_misalign", idx), 32'(misalign_o), 32'(v.exp_mis));
    tick();
    MemRead_i  = 1'b0;
    MemWrite_i = 1'b0;
    #1;
    chk($sformatf("v%0d_done_clear", idx), 32'(mem_done_o), 32'd0);
    chk($sformatf("v%0d_idle_stall", idx), 32'(stall_o), 32'd0);
  endtask

  // Store aborted by reset during the given BUSY cycle (1 = first BUSY cycle).
  task automatic abort_store(input logic [31:0] a, input logic [31:0] d, input int busy_k);
    MemWrite_i  = 1'b1;
    MemRead_i   = 1'b0;
    Addr_i      = a;
    WriteData_i = d;
    #1;
    chk("abort_stall_start", 32'(stall_o), 32'd1);
    for (int i = 0; i < busy_k; i++) tick();
    chk("abort_stall_busy", 32'(stall_o), 32'd1);
    rst_i = 1'b1;
    tick();
    rst_i      = 1'b0;
    MemWrite_i = 1'b0;
    #1;
    chk("abort_stall", 32'(stall_o), 32'd0);
    chk("abort_done", 32'(mem_done_o), 32'd0);
    chk("abort_rdata", ReadData_o, 32'h0000_0000);
    for (int i = 0; i < LATENCY + 2; i++) begin
      tick();
      chk("abort_no_late_done", 32'(mem_done_o), 32'd0);
    end
  endtask

  initial begin
    vec_t v;
    //        rd    wr    addr          wdata         exp_rd                                   exp_mis
    tbl[0]  = '{1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0};
    tbl[1]  = '{1'b1, 1'b0, 32'h0000_0010, 32'h0000_0000, 32'hDEAD_BEEF, 1'b0};
    tbl[2]  = '{1'b1, 1'b1, 32'h0000_0020, 32'h1234_5678, 32'hDEAD_BEEF, 1'b0};
    tbl[3]  = '{1'b1, 1'b0, 32'h0000_0020, 32'h0000_0000, 32'h1234_5678, 1'b0};
    tbl[4]  = '{1'b0, 1'b1, 32'h0000_07FC, 32'hCAFE_F00D, 32'h1234_5678, 1'b0};
    tbl[5]  = '{1'b1, 1'b0, 32'h0000_03FC, 32'h0000_0000, 32'hCAFE_F00D, 1'b0};
    tbl[6]  = '{1'b0, 1'b1, 32'h0000_0000, 32'h1111_1111, 32'hCAFE_F00D, 1'b0};
    tbl[7]  = '{1'b1, 1'b0, 32'h0000_0400, 32'h0000_0000, 32'h1111_1111, 1'b0};
    tbl[8]  = '{1'b1, 1'b0, 32'h0000_0410, 32'h0000_0000, 32'hDEAD_BEEF, 1'b0};
    tbl[9]  = '{1'b1, 1'b0, 32'h0000_0020, 32'h0000_0000, 32'h1234_5678, 1'b0};
    tbl[10] = '{1'b1, 1'b0, 32'h0000_0013, 32'h0000_0000,
                MIS_EN ? 32'h1234_5678 : 32'hDEAD_BEEF, MIS_EN};
    tbl[11] = '{1'b0, 1'b1, 32'h0000_0011, 32'hBADB_AD00,
                MIS_EN ? 32'h1234_5678 : 32'hDEAD_BEEF, MIS_EN};
    tbl[12] = '{1'b1, 1'b0, 32'h0000_0010, 32'h0000_0000,
                MIS_EN ? 32'hDEAD_BEEF : 32'hBADB_AD00, 1'b0};

    rst_i       = 1'b1;
    MemRead_i   = 1'b0;
    MemWrite_i  = 1'b0;
    Addr_i      = 32'h0000_0000;
    WriteData_i = 32'h0000_0000;
    tick();
    tick();
    rst_i = 1'b0;
    #1;
    chk("reset_stall", 32'(stall_o), 32'd0);
    chk("reset_done", 32'(mem_done_o), 32'd0);
    chk("reset_rdata", ReadData_o, 32'h0000_0000);
    chk("reset_misalign", 32'(misalign_o), 32'd0);

    for (int i = 0; i < 13; i++) access(tbl[i], i);
    last_r = tbl[12].exp_rd;

    // Non-memory cycles with wiggling address/data: no stall, no access.
    for (int i = 0; i < 10; i++) begin
      Addr_i      = $urandom;
      WriteData_i = $urandom;
      #1;
      chk("idle_stall", 32'(stall_o), 32'd0);
      chk("idle_done", 32'(mem_done_o), 32'd0);
      tick();
    end
    chk("idle_rdata_hold", ReadData_o, last_r);

    v = '{1'b0, 1'b1, 32'h0000_0020, 32'hAAAA_0000, last_r, 1'b0};
    access(v, 100);
    abort_store(32'h0000_0020, 32'h5555_FFFF, 2);
    abort_store(32'h0000_0020, 32'h5555_FFFF, LATENCY);
    v = '{1'b1, 1'b0, 32'h0000_0020, 32'h0000_0000, 32'hAAAA_0000, 1'b0};
    access(v, 101);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
